// File: rtl/clkgen_pkg.sv
// Shared constants and types for the multi-channel clock/tone generator.
// Optional duty-cycle mode is selected by the macro CLKGEN_DUTY_EN.
package clkgen_pkg;

  localparam int CLKGEN_N   = 16;
  localparam int CLKGEN_NCH = 4;

  // Channel configuration at the default counter width.
  typedef struct packed {
    logic [CLKGEN_N-1:0] period;
    logic [CLKGEN_N-1:0] duty;
  } clkgen_cfg_t;

endpackage

// File: rtl/clkgen_if.sv
// Configuration write bus for clkgen_multi: one shadow-register write per cycle.
// cfg_duty only matters when CLKGEN_DUTY_EN is defined.
interface clkgen_if
  import clkgen_pkg::*;
#(
  parameter int N   = CLKGEN_N,
  parameter int NCH = CLKGEN_NCH
);
  localparam int CHW = $clog2(NCH);

  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [N-1:0]   cfg_period;
  logic [N-1:0]   cfg_duty;

  modport master (output cfg_we, output cfg_ch, output cfg_period, output cfg_duty);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_period, input  cfg_duty);

endinterface

// File: rtl/clkgen_chan.sv
// One generator channel: period counter, shadow/active config, registered tone and tick.
// With CLKGEN_DUTY_EN the tone follows a programmable high time, otherwise it toggles per wrap.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int N = CLKGEN_N
) (
  input  logic         clk_i,
  input  logic         reset,
  input  logic         en,
  input  logic         sync,
  input  logic         wr,
  input  logic [N-1:0] wr_period,
`ifdef CLKGEN_DUTY_EN
  input  logic [N-1:0] wr_duty,
`endif
  output logic         pend,
  output logic         tone_p1,
  output logic         tick_p1
);

  logic [N-1:0] ctr;
  logic [N-1:0] per_a;
  logic [N-1:0] per_s;
`ifdef CLKGEN_DUTY_EN
  logic [N-1:0] duty_a;
  logic [N-1:0] duty_s;
`endif

  logic wrap;
  logic restart;
  logic load;

  // Reload happens only at a counter restart, so the active config never changes mid-period.
  always_comb begin
    wrap    = en && (ctr >= per_a);
    restart = sync || !en || wrap;
    load    = pend && restart;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      ctr     <= '0;
      per_a   <= '0;
      per_s   <= '0;
`ifdef CLKGEN_DUTY_EN
      duty_a  <= '0;
      duty_s  <= '0;
`endif
      pend    <= 1'b0;
      tone_p1 <= 1'b0;
      tick_p1 <= 1'b0;
    end else begin
      // Active regs take the shadow as it was before any same-cycle write.
      if (load) begin
        per_a  <= per_s;
`ifdef CLKGEN_DUTY_EN
        duty_a <= duty_s;
`endif
      end
      if (wr) begin
        per_s  <= wr_period;
`ifdef CLKGEN_DUTY_EN
        duty_s <= wr_duty;
`endif
      end
      pend <= wr || (pend && !load);

      if (restart) ctr <= '0;
      else         ctr <= ctr + 1'b1;

      tick_p1 <= wrap && !sync;

`ifdef CLKGEN_DUTY_EN
      tone_p1 <= en && (ctr < duty_a);
`else
      if (sync || !en) tone_p1 <= 1'b0;
      else if (wrap)   tone_p1 <= !tone_p1;
`endif
    end
  end

endmodule

// File: rtl/clkgen_multi.sv
// NCH-channel programmable clock/tone generator with shadowed, period-aligned reconfiguration.
// Define CLKGEN_DUTY_EN for programmable duty; default build gives 50% toggled outputs.
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int N   = CLKGEN_N,
  parameter int NCH = CLKGEN_NCH
) (
  input  logic           clk_i,
  input  logic           reset,
  input  logic [NCH-1:0] en_i,
  input  logic           sync_i,
  clkgen_if.slave        cfg,
  output logic [NCH-1:0] pend_o,
  output logic [NCH-1:0] clk_o,
  output logic [NCH-1:0] tick_o
);

  localparam int CHW = $clog2(NCH);

`ifndef CLKGEN_DUTY_EN
  logic unused_duty;
  assign unused_duty = ^cfg.cfg_duty;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic wr_hit;
    assign wr_hit = cfg.cfg_we && (cfg.cfg_ch == CHW'(i));

    clkgen_chan #(.N(N)) u_chan (
      .clk_i     (clk_i),
      .reset     (reset),
      .en        (en_i[i]),
      .sync      (sync_i),
      .wr        (wr_hit),
      .wr_period (cfg.cfg_period),
`ifdef CLKGEN_DUTY_EN
      .wr_duty   (cfg.cfg_duty),
`endif
      .pend      (pend_o[i]),
      .tone_p1   (clk_o[i]),
      .tick_p1   (tick_o[i])
    );
  end

endmodule
